// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch handshake, stage counter, PC and issue register.
// Defining CPU_SEQ_PERF_COUNTERS_EN adds the cycle_count and retired_count counters.
module cpu_sequencer #(
  parameter int XLEN = 32,
  parameter int PC_WIDTH = 32,
  parameter int NUM_STAGES = 5,
  parameter int PC_STEP = 1,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  localparam int SW = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_req,
  output logic [PC_WIDTH-1:0] mem_addr,
  input  logic                mem_ready,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_rvalid,
  input  logic                ex_busy,
  input  logic                jump_taken,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                halt_req,
  output logic [SW-1:0]       stage,
  output logic [XLEN-1:0]     instr,
  output logic [PC_WIDTH-1:0] pc,
  output logic                instr_valid,
  output logic                retire,
  output logic                halted
`ifdef CPU_SEQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]         cycle_count,
  output logic [31:0]         retired_count
`endif
);

  typedef enum logic [1:0] {FETCH_REQ, FETCH_WAIT, EXEC, HALTED} state_t;

  localparam logic [SW-1:0]       LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [PC_WIDTH-1:0] PC_INC     = PC_WIDTH'(PC_STEP);

  state_t state;
  logic   last_stage;

  assign mem_req    = (state == FETCH_REQ);
  assign mem_addr   = pc;
  assign last_stage = (stage == LAST_STAGE);
  assign retire     = (state == EXEC) && last_stage && !ex_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH_REQ;
      pc          <= RESET_PC;
      instr       <= '0;
      stage       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        FETCH_REQ: begin
          if (mem_ready) state <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (mem_rvalid) begin
            instr       <= mem_rdata;
            stage       <= SW'(1);
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (!ex_busy) begin
            if (!last_stage) begin
              stage <= stage + SW'(1);
            end else begin
              // Completion: halt wins over jump, jump wins over sequential flow.
              stage       <= '0;
              instr_valid <= 1'b0;
              if (halt_req) begin
                state  <= HALTED;
                halted <= 1'b1;
              end else begin
                state <= FETCH_REQ;
                pc    <= jump_taken ? jump_target : pc + PC_INC;
              end
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: state <= FETCH_REQ;
      endcase
    end
  end

`ifdef CPU_SEQ_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      if (!halted) cycle_count <= cycle_count + 32'd1;
      if (retire) retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Parametrised multi-cycle instruction sequencer. Combines the stage counter, PC register, issue register and fetch control of the core into one block.
Adds over the fixed-stage core:
- variable-latency instruction memory handshake
- execute-stage stall input
- jump redirect
- halt state
- configurable stage count, widths and PC step
Decoder, ALU and register file attach to its instr/stage/pc outputs.

Parameters:
XLEN, 32, instruction/data word width
PC_WIDTH, 32, program counter and fetch address width
NUM_STAGES, 5, stages per instruction including fetch stage 0; must be >= 2
PC_STEP, 1, sequential PC increment (1 = word-addressed, 4 = byte-addressed)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
mem_req  output  1  instruction fetch request
mem_addr  output  PC_WIDTH  fetch address; equals pc
mem_ready  input  1  memory accepts request when mem_req && mem_ready
mem_rdata  input  XLEN  fetched instruction
mem_rvalid  input  1  mem_rdata valid; earliest one cycle after acceptance
ex_busy  input  1  holds the current non-fetch stage
jump_taken  input  1  redirect request, sampled in the last stage only
jump_target  input  PC_WIDTH  redirect address
halt_req  input  1  halt request, sampled in the last stage only
stage  output  SW  current stage index, SW = max(1, clog2(NUM_STAGES))
instr  output  XLEN  issue register contents
pc  output  PC_WIDTH  address of the current instruction
instr_valid  output  1  instr holds a live instruction (stages 1..NUM_STAGES-1)
retire  output  1  one-cycle pulse when the instruction completes
halted  output  1  core is halted

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-high; one clock domain.
- States: FETCH_REQ, FETCH_WAIT, EXEC, HALTED.
- Reset values:
  - state FETCH_REQ
  - pc = RESET_PC
  - instr = 0
  - stage = 0
  - instr_valid = 0
  - halted = 0
  - retire = 0
- mem_req = 1 only in FETCH_REQ (combinational from state). mem_addr = pc at all times.
- FETCH_REQ:
  - Stay while !mem_ready; mem_addr stays stable.
  - On mem_ready, go to FETCH_WAIT.
  - Any mem_rvalid in this state is ignored.
- FETCH_WAIT:
  - mem_req = 0.
  - On mem_rvalid: instr <= mem_rdata, stage <= 1, instr_valid <= 1, go to EXEC.
  - Otherwise wait indefinitely; there is no timeout.
- EXEC:
  - If ex_busy, stage holds.
  - Else if stage < NUM_STAGES-1, stage increments by 1.
  - Else (last stage, !ex_busy), the instruction completes:
    - retire = 1 for this cycle (combinational: EXEC && stage == last && !ex_busy).
    - Priority halt_req > jump_taken > sequential.
    - halt_req: pc unchanged, go to HALTED, halted <= 1, instr_valid <= 0, stage <= 0.
    - jump_taken: pc <= jump_target.
    - Sequential: pc <= pc + PC_STEP, wrapping modulo 2^PC_WIDTH.
    - For jump and sequential: stage <= 0, instr_valid <= 0, go to FETCH_REQ.
  - instr is held constant throughout EXEC.
- Timing:
  - Minimum instruction time: NUM_STAGES + 1 cycles (1 request, ≥1 wait, NUM_STAGES-1 exec) when mem_ready = 1 and rvalid arrives one cycle after acceptance.
  - Each ex_busy cycle adds exactly one cycle.
- HALTED:
  - All inputs ignored; mem_req = 0; retire = 0; halted = 1.
  - Exit only via rst.
- jump_taken and halt_req outside the last stage, or while ex_busy, have no effect.
- Reset mid-operation clears all state asynchronously. The instruction memory must be reset with the same rst, so no stale responses are delivered.

Optional Feature:
Macro CPU_SEQ_PERF_COUNTERS_EN.
- When defined, adds two ports:
  - cycle_count  output  32: increments every cycle while !halted.
  - retired_count  output  32: increments on each retire pulse.
- Both counters reset to 0 and wrap at 2^32.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. RESET_PC=0x100, NUM_STAGES=5, release rst, mem_ready=1, rvalid 1 cycle after acceptance with rdata=0xDEADBEEF -> mem_addr=0x100; instr=0xDEADBEEF; stage runs 1,2,3,4; retire pulses once; next mem_addr=0x101; 6 cycles per instruction.
2. mem_ready low 3 cycles, then rvalid 4 cycles after acceptance -> mem_req held high 4 cycles with mem_addr stable; stage=0 and instr_valid=0 throughout; instruction takes 6 extra cycles.
3. ex_busy high 2 cycles at stage 2 -> stage reads 2 for 3 cycles; retire delayed by exactly 2 cycles; instr unchanged.
4. At last stage, jump_taken=1 with target 0x40 -> next mem_addr=0x40. Repeat with halt_req=1 and jump_taken=1 together -> halted=1, pc unchanged, mem_req stays 0 for 20 cycles.
5. PC_WIDTH=8, PC_STEP=4, pc=0xFC, no jump -> next pc=0x00.
6. Assert rst mid FETCH_WAIT and mid EXEC stage 3 -> outputs reset in the same cycle without a clock edge; the next fetch goes to RESET_PC. With CPU_SEQ_PERF_COUNTERS_EN, both counters read 0 after reset and retired_count=3 after three retires.
